// File: rtl/pll_reset_ctrl_pkg.sv
// Shared types and constants for the PLL reset controller.
package pll_rst_pkg;

   typedef enum logic [1:0] {
      PLL_RESET = 2'd0,
      WAIT_LOCK = 2'd1,
      STABILIZE = 2'd2,
      RUN       = 2'd3
   } pll_state_e;

   localparam int RETRY_W = 8;
   localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

   // Saturating increment: the count is diagnostic and must never wrap back to a small value.
   function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] v);
      return (v == RETRY_MAX) ? v : v + 1'b1;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pll_reset_ctrl_if.sv
// PLL-side and system-side reset signals of the controller.
// master: the controller; slave: the PLL / observer side.
interface pll_reset_ctrl_if;
   logic                             pll_locked;
   logic                             pll_rst;
   logic                             sys_rst_n;
   logic                             lock_lost;
   logic [pll_rst_pkg::RETRY_W-1:0]  retry_count;

   modport master (
      input  pll_locked,
      output pll_rst,
      output sys_rst_n,
      output lock_lost,
      output retry_count
   );

   modport slave (
      output pll_locked,
      input  pll_rst,
      input  sys_rst_n,
      input  lock_lost,
      input  retry_count
   );
endinterface

// File: rtl/pll_reset_ctrl_bit_sync.sv
// Multi-flop single-bit synchroniser, cleared to 0 on reset.
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock and only then
// releases the system reset. Retries on lock timeout and re-resets on loss of lock.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  PLL_RESET | pll_rst held high for PLL_RST_CYCLES cycles
//  WAIT_LOCK | PLL released, waiting for locked; retry after LOCK_TIMEOUT
//  STABILIZE | locked seen, must stay high LOCK_STABLE_CYCLES cycles
//  RUN       | system reset released; any drop of lock restarts the PLL
module pll_reset_ctrl
   import pll_rst_pkg::*;
#(
   parameter int SYNC_STAGES        = 2,
   parameter int PLL_RST_CYCLES     = 16,
   parameter int LOCK_TIMEOUT       = 1000000,
   parameter int LOCK_STABLE_CYCLES = 4096
) (
   input  logic             refclk,
   input  logic             rst_n,
   pll_reset_ctrl_if.master pll_if
);

   localparam int MAX_CYC = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES);
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

   pll_state_e          state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                pll_rst_q;
   logic                sys_rst_n_q;
   logic                lock_lost_q;
   logic [RETRY_W-1:0]  retry_q;
   logic                locked_s;

   bit_sync #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk_i   (refclk),
      .rst_n_i (rst_n),
      .d_i     (pll_if.pll_locked),
      .q_o     (locked_s)
   );

   // Sequencer: outputs are set alongside each transition so they track the state register.
   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         state_q     <= PLL_RESET;
         cnt_q       <= '0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         lock_lost_q <= 1'b0;
         retry_q     <= '0;
      end else begin
         lock_lost_q <= 1'b0;
         case (state_q)
            PLL_RESET: begin
               if (cnt_q == RST_LAST) begin
                  state_q   <= WAIT_LOCK;
                  cnt_q     <= '0;
                  pll_rst_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  state_q <= STABILIZE;
                  cnt_q   <= '0;
               end else if (cnt_q == TO_LAST) begin
                  state_q   <= PLL_RESET;
                  cnt_q     <= '0;
                  pll_rst_q <= 1'b1;
                  retry_q   <= retry_inc(retry_q);
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            STABILIZE: begin
               // Any drop restarts the whole lock search, including its timeout.
               if (!locked_s) begin
                  state_q <= WAIT_LOCK;
                  cnt_q   <= '0;
               end else if (cnt_q == STB_LAST) begin
                  state_q     <= RUN;
                  cnt_q       <= '0;
                  sys_rst_n_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RUN: begin
               if (!locked_s) begin
                  state_q     <= PLL_RESET;
                  cnt_q       <= '0;
                  pll_rst_q   <= 1'b1;
                  sys_rst_n_q <= 1'b0;
                  lock_lost_q <= 1'b1;
                  retry_q     <= retry_inc(retry_q);
               end
            end
            default: begin
               state_q     <= PLL_RESET;
               cnt_q       <= '0;
               pll_rst_q   <= 1'b1;
               sys_rst_n_q <= 1'b0;
            end
         endcase
      end
   end

   assign pll_if.pll_rst     = pll_rst_q;
   assign pll_if.sys_rst_n   = sys_rst_n_q;
   assign pll_if.lock_lost   = lock_lost_q;
   assign pll_if.retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: stimulus pushes expected output changes (cycle + value)
// into a queue; a monitor pops one entry whenever the output tuple changes.
module tb_pll_reset_ctrl;

   typedef struct {
      int          cyc;
      logic [10:0] vec;   // {pll_rst, sys_rst_n, lock_lost, retry_count}
   } ev_t;

   logic refclk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_pass;
   ev_t  exp_q[$];

   pll_reset_ctrl_if pll_if();

   pll_reset_ctrl #(
      .SYNC_STAGES        (2),
      .PLL_RST_CYCLES     (4),
      .LOCK_TIMEOUT       (20),
      .LOCK_STABLE_CYCLES (8)
   ) dut (
      .refclk (refclk),
      .rst_n  (rst_n),
      .pll_if (pll_if)
   );

   initial begin
      refclk = 1'b0;
      forever #5 refclk = ~refclk;
   end

   initial cyc = 0;
   always @(posedge refclk) cyc = cyc + 1;

   task automatic tick(input int n);
      repeat (n) @(negedge refclk);
   endtask

   task automatic push(input int c, input logic pr, input logic sr, input logic ll,
                       input logic [7:0] rc);
      ev_t e;
      e.cyc = c;
      e.vec = {pr, sr, ll, rc};
      exp_q.push_back(e);
   endtask

   // Monitor: every change of the output tuple must match the next expected event.
   logic [10:0] prev_vec;
   logic [10:0] cur_vec;
   bit          have_prev;
   ev_t         got_e;
   initial have_prev = 1'b0;
   always @(negedge refclk) begin
      cur_vec = {pll_if.pll_rst, pll_if.sys_rst_n, pll_if.lock_lost, pll_if.retry_count};
      if (!have_prev || cur_vec != prev_vec) begin
         n_checks = n_checks + 1;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_change cyc=%0d got rst/sys/lost/retry=%b/%b/%b/%0d required none",
                     cyc, cur_vec[10], cur_vec[9], cur_vec[8], cur_vec[7:0]);
         end else begin
            got_e = exp_q.pop_front();
            if (got_e.cyc == cyc && got_e.vec == cur_vec) begin
               n_pass = n_pass + 1;
            end else begin
               $display("FAIL event got cyc=%0d rst/sys/lost/retry=%b/%b/%b/%0d required cyc=%0d %b/%b/%b/%0d",
                        cyc, cur_vec[10], cur_vec[9], cur_vec[8], cur_vec[7:0],
                        got_e.cyc, got_e.vec[10], got_e.vec[9], got_e.vec[8], got_e.vec[7:0]);
            end
         end
      end
      prev_vec  = cur_vec;
      have_prev = 1'b1;
   end

   initial begin
      int k;
      int q;
      logic [7:0] rc;
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      pll_if.pll_locked = 1'b0;

      // 1: reset values, then pll_rst held 4 cycles after release
      push(1, 1'b1, 1'b0, 1'b0, 8'd0);
      tick(3);
      rst_n = 1'b1;
      k = cyc;
      push(k + 4, 1'b0, 1'b0, 1'b0, 8'd0);
      tick(4);

      // 2: lock 2 cycles into WAIT_LOCK -> release 11 cycles after first high sample
      tick(2);
      k = cyc;
      pll_if.pll_locked = 1'b1;
      push(k + 11, 1'b0, 1'b1, 1'b0, 8'd0);
      tick(14);

      // 5: loss of lock in RUN
      k = cyc;
      pll_if.pll_locked = 1'b0;
      push(k + 3, 1'b1, 1'b0, 1'b1, 8'd1);
      push(k + 4, 1'b1, 1'b0, 1'b0, 8'd1);
      push(k + 7, 1'b0, 1'b0, 1'b0, 8'd1);
      tick(8);

      // 3: 5-cycle lock glitch in STABILIZE, timeout restarts from the drop
      k = cyc;
      pll_if.pll_locked = 1'b1;
      tick(5);
      pll_if.pll_locked = 1'b0;
      push(k + 28, 1'b1, 1'b0, 1'b0, 8'd2);
      push(k + 32, 1'b0, 1'b0, 1'b0, 8'd2);
      tick(27);

      // 4: repeated timeouts every 24 cycles, retry saturates at 255
      q = cyc;
      for (int i = 0; i < 260; i++) begin
         rc = (3 + i > 255) ? 8'd255 : 8'(3 + i);
         push(q + 20 + 24 * i, 1'b1, 1'b0, 1'b0, rc);
         push(q + 24 + 24 * i, 1'b0, 1'b0, 1'b0, rc);
      end
      tick(24 * 260);

      // 6a: reset during STABILIZE
      tick(1);
      k = cyc;
      pll_if.pll_locked = 1'b1;
      tick(5);
      rst_n = 1'b0;
      push(k + 6, 1'b1, 1'b0, 1'b0, 8'd0);
      tick(2);
      rst_n = 1'b1;
      push(k + 11, 1'b0, 1'b0, 1'b0, 8'd0);
      push(k + 20, 1'b0, 1'b1, 1'b0, 8'd0);
      tick(16);

      // 6b: reset during RUN
      rst_n = 1'b0;
      push(k + 24, 1'b1, 1'b0, 1'b0, 8'd0);
      tick(2);
      rst_n = 1'b1;
      push(k + 29, 1'b0, 1'b0, 1'b0, 8'd0);
      push(k + 38, 1'b0, 1'b1, 1'b0, 8'd0);
      tick(20);

      // every expected event must have been observed
      n_checks = n_checks + 1;
      if (exp_q.size() == 0) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL events_missing got %0d pending required 0 (next due cyc=%0d)",
                  exp_q.size(), exp_q[0].cyc);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
